// File: rtl/ex_wb_pipeline.sv
// ---------------------------------------------------------------------------
// ex_wb_pipeline
// Back half of a five-stage integer pipeline: the EX/MEM and MEM/WB pipeline
// registers, the register-file write port, and a load-use hazard detector
// with a saturating stall counter.
//
// Writes to X31 are squashed where they enter EX/MEM, so a write enable is
// never paired with destination 31 further down the pipe. The hazard unit
// inserts at most one bubble per load. While it sits in HOLD the bubble
// occupies EX, so the load has already moved to MEM and forwarding covers
// the dependency from there.
//
// STALL_CNT_MAX sets the value at which stall_count stops counting.
// ---------------------------------------------------------------------------
module ex_wb_pipeline #(
   parameter logic [15:0] STALL_CNT_MAX = 16'hFFFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ex_valid,
   input  logic [4:0]  ex_rd,
   input  logic        ex_regwrite,
   input  logic        ex_memread,
   input  logic [63:0] ex_alu_result,
   input  logic        flush,
   input  logic [63:0] mem_rdata,
   input  logic [4:0]  id_regA,
   input  logic [4:0]  id_regB,
   output logic        ExRegWrite,
   output logic        MemRegWrite,
   output logic [4:0]  ExRd,
   output logic [4:0]  MemRd,
   output logic [63:0] ex_mem_result,
   output logic [63:0] mem_wb_result,
   output logic        wb_en,
   output logic [4:0]  wb_rd,
   output logic [63:0] wb_data,
   output logic        stall,
   output logic [15:0] stall_count
);

   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_HOLD = 1'b1
   } hz_state_t;

   hz_state_t r_state;
   logic      r_ex_memread;

   logic      w_ex_we;
   logic      w_ex_load;
   logic      w_hazard;
   logic      w_stall;

   // A surviving register write: real instruction, not squashed, not X31
   assign w_ex_we   = ex_valid & ex_regwrite & ~flush & (ex_rd != 5'd31);
   // A surviving load: its MEM-stage result comes from data memory
   assign w_ex_load = ex_valid & ex_memread & ~flush;
   // Load in EX whose destination is read by the instruction in ID
   assign w_hazard  = ex_valid & ex_memread & ex_regwrite & ~flush &
                      (ex_rd != 5'd31) &
                      ((ex_rd == id_regA) | (ex_rd == id_regB));

   // Stall request: only raised from RUN, never while reset is asserted
   always_comb begin
      w_stall = 1'b0;
      if (reset) begin
         w_stall = 1'b0;
      end else if (r_state == ST_RUN) begin
         w_stall = w_hazard;
      end else begin
         w_stall = 1'b0;
      end
   end

   assign stall = w_stall;

   // EX/MEM pipeline register: captures every edge, bubbles squashed entries
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ExRegWrite    <= 1'b0;
         ExRd          <= 5'd31;
         ex_mem_result <= 64'd0;
         r_ex_memread  <= 1'b0;
      end else begin
         ExRegWrite    <= w_ex_we;
         ExRd          <= w_ex_we ? ex_rd : 5'd31;
         ex_mem_result <= ex_alu_result;
         r_ex_memread  <= w_ex_load;
      end
   end

   // MEM/WB pipeline register: selects load data or ALU result for write-back
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         MemRegWrite   <= 1'b0;
         MemRd         <= 5'd31;
         mem_wb_result <= 64'd0;
      end else begin
         MemRegWrite   <= ExRegWrite;
         MemRd         <= ExRd;
         mem_wb_result <= r_ex_memread ? mem_rdata : ex_mem_result;
      end
   end

   // Hazard FSM and saturating stall counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_RUN;
         stall_count <= 16'd0;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (w_stall) begin
                  r_state <= ST_HOLD;
               end else begin
                  r_state <= ST_RUN;
               end
            end
            ST_HOLD: begin
               r_state <= ST_RUN;
            end
            default: begin
               r_state <= ST_RUN;
            end
         endcase
         if (w_stall && (stall_count < STALL_CNT_MAX)) begin
            stall_count <= stall_count + 16'd1;
         end
      end
   end

   // Register-file write port mirrors the MEM/WB register
   assign wb_en   = MemRegWrite;
   assign wb_rd   = MemRd;
   assign wb_data = mem_wb_result;

endmodule

// File: tb/tb_ex_wb_pipeline.sv
// ---------------------------------------------------------------------------
// tb_ex_wb_pipeline
// Self-checking bench for ex_wb_pipeline: a table of single-instruction
// vectors, hand-written multi-cycle sequences, and randomized traffic, all
// checked against a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_ex_wb_pipeline;

   localparam logic [15:0] SAT = 16'd300;

   logic        clk;
   logic        reset;
   logic        ex_valid;
   logic [4:0]  ex_rd;
   logic        ex_regwrite;
   logic        ex_memread;
   logic [63:0] ex_alu_result;
   logic        flush;
   logic [63:0] mem_rdata;
   logic [4:0]  id_regA;
   logic [4:0]  id_regB;
   logic        ExRegWrite;
   logic        MemRegWrite;
   logic [4:0]  ExRd;
   logic [4:0]  MemRd;
   logic [63:0] ex_mem_result;
   logic [63:0] mem_wb_result;
   logic        wb_en;
   logic [4:0]  wb_rd;
   logic [63:0] wb_data;
   logic        stall;
   logic [15:0] stall_count;

   ex_wb_pipeline #(.STALL_CNT_MAX(SAT)) dut (
      .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_rd(ex_rd),
      .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
      .ex_alu_result(ex_alu_result), .flush(flush), .mem_rdata(mem_rdata),
      .id_regA(id_regA), .id_regB(id_regB),
      .ExRegWrite(ExRegWrite), .MemRegWrite(MemRegWrite),
      .ExRd(ExRd), .MemRd(MemRd),
      .ex_mem_result(ex_mem_result), .mem_wb_result(mem_wb_result),
      .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
      .stall(stall), .stall_count(stall_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          valid;
      bit          rw;
      bit          mr;
      bit          fl;
      logic [4:0]  rd;
      logic [4:0]  ra;
      logic [4:0]  rb;
      logic [63:0] alu;
      logic [63:0] rdata;
   } in_t;

   typedef struct {
      in_t        in;
      bit         exp_stall;
      bit         exp_exw;
      logic [4:0] exp_exrd;
   } vec_t;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model: what each pipeline slot should hold after the last edge
   bit          m_exw;
   logic [4:0]  m_exrd;
   logic [63:0] m_exres;
   bit          m_exld;
   bit          m_memw;
   logic [4:0]  m_memrd;
   logic [63:0] m_memres;
   bit          m_hold;
   int          m_cnt;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic in_t mk(bit v, bit rw, bit mr, bit fl, logic [4:0] rd,
                              logic [4:0] ra, logic [4:0] rb,
                              logic [63:0] alu, logic [63:0] rdata);
      in_t t;
      t.valid = v;  t.rw = rw;  t.mr = mr;  t.fl = fl;
      t.rd = rd;    t.ra = ra;  t.rb = rb;  t.alu = alu;  t.rdata = rdata;
      return t;
   endfunction

   // Load-use: a load that survives and produces a real register read by ID
   function automatic bit load_use(in_t v);
      return v.valid && v.mr && v.rw && !v.fl && (v.rd != 5'd31) &&
             ((v.rd == v.ra) || (v.rd == v.rb));
   endfunction

   task automatic model_reset();
      m_exw = 1'b0;  m_exrd = 5'd31;  m_exres = 64'd0;  m_exld = 1'b0;
      m_memw = 1'b0; m_memrd = 5'd31; m_memres = 64'd0;
      m_hold = 1'b0; m_cnt = 0;
   endtask

   task automatic check_regs();
      chk("ExRegWrite",    64'(ExRegWrite),    64'(m_exw));
      chk("ExRd",          64'(ExRd),          64'(m_exrd));
      chk("ex_mem_result", ex_mem_result,      m_exres);
      chk("MemRegWrite",   64'(MemRegWrite),   64'(m_memw));
      chk("MemRd",         64'(MemRd),         64'(m_memrd));
      chk("mem_wb_result", mem_wb_result,      m_memres);
      chk("wb_en",         64'(wb_en),         64'(m_memw));
      chk("wb_rd",         64'(wb_rd),         64'(m_memrd));
      chk("wb_data",       wb_data,            m_memres);
      chk("stall_count",   64'(stall_count),   64'(m_cnt));
   endtask

   task automatic check_reset_values();
      chk("rst_ExRegWrite",  64'(ExRegWrite),  64'd0);
      chk("rst_MemRegWrite", 64'(MemRegWrite), 64'd0);
      chk("rst_wb_en",       64'(wb_en),       64'd0);
      chk("rst_ExRd",        64'(ExRd),        64'd31);
      chk("rst_MemRd",       64'(MemRd),       64'd31);
      chk("rst_wb_rd",       64'(wb_rd),       64'd31);
      chk("rst_ex_mem",      ex_mem_result,    64'd0);
      chk("rst_mem_wb",      mem_wb_result,    64'd0);
      chk("rst_wb_data",     wb_data,          64'd0);
      chk("rst_stall",       64'(stall),       64'd0);
      chk("rst_stall_count", 64'(stall_count), 64'd0);
   endtask

   // One cycle: entered and left at a falling edge
   task automatic step(input in_t v, output bit got_stall);
      bit exp_stall;
      check_regs();
      ex_valid = v.valid;  ex_regwrite = v.rw;  ex_memread = v.mr;
      flush = v.fl;        ex_rd = v.rd;        id_regA = v.ra;
      id_regB = v.rb;      ex_alu_result = v.alu;  mem_rdata = v.rdata;
      #1;
      exp_stall = !m_hold && load_use(v);
      got_stall = stall;
      chk("stall", 64'(stall), 64'(exp_stall));
      m_memres = m_exld ? v.rdata : m_exres;
      m_memw   = m_exw;
      m_memrd  = m_exrd;
      m_exw    = v.valid && v.rw && !v.fl && (v.rd != 5'd31);
      m_exrd   = m_exw ? v.rd : 5'd31;
      m_exres  = v.alu;
      m_exld   = v.valid && v.mr && !v.fl;
      m_hold   = exp_stall;
      if (exp_stall && (m_cnt < int'(SAT))) m_cnt++;
      @(negedge clk);
   endtask

   vec_t vecs[11];
   in_t  bub;
   in_t  ld3;
   bit   s;
   int   cnt0;

   initial begin
      bub = mk(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 64'd0, 64'd0);
      ld3 = mk(1'b1, 1'b1, 1'b1, 1'b0, 5'd3, 5'd9, 5'd3, 64'h100, 64'd0);
      //                 v     rw    mr    fl    rd     ra     rb     alu
      vecs[0]  = '{mk(1'b1,1'b1,1'b0,1'b0,5'd5, 5'd0, 5'd0, 64'h1234,64'd0), 1'b0,1'b1,5'd5};
      vecs[1]  = '{mk(1'b1,1'b1,1'b1,1'b0,5'd3, 5'd0, 5'd3, 64'h40,  64'd0), 1'b1,1'b1,5'd3};
      vecs[2]  = '{mk(1'b1,1'b1,1'b1,1'b0,5'd3, 5'd3, 5'd0, 64'h48,  64'd0), 1'b1,1'b1,5'd3};
      vecs[3]  = '{mk(1'b1,1'b1,1'b1,1'b0,5'd3, 5'd3, 5'd3, 64'h50,  64'd0), 1'b1,1'b1,5'd3};
      vecs[4]  = '{mk(1'b1,1'b1,1'b1,1'b0,5'd3, 5'd4, 5'd5, 64'h58,  64'd0), 1'b0,1'b1,5'd3};
      vecs[5]  = '{mk(1'b1,1'b1,1'b1,1'b1,5'd3, 5'd3, 5'd3, 64'h60,  64'd0), 1'b0,1'b0,5'd31};
      vecs[6]  = '{mk(1'b1,1'b1,1'b0,1'b0,5'd31,5'd0, 5'd0, 64'h77,  64'd0), 1'b0,1'b0,5'd31};
      vecs[7]  = '{mk(1'b1,1'b1,1'b1,1'b0,5'd31,5'd31,5'd31,64'h68,  64'd0), 1'b0,1'b0,5'd31};
      vecs[8]  = '{mk(1'b0,1'b1,1'b1,1'b0,5'd3, 5'd3, 5'd3, 64'h70,  64'd0), 1'b0,1'b0,5'd31};
      vecs[9]  = '{mk(1'b1,1'b0,1'b1,1'b0,5'd3, 5'd3, 5'd3, 64'h78,  64'd0), 1'b0,1'b0,5'd31};
      vecs[10] = '{mk(1'b1,1'b1,1'b0,1'b0,5'd7, 5'd7, 5'd7, 64'h80,  64'd0), 1'b0,1'b1,5'd7};

      // Reset phase: hold reset with a hazard on the inputs
      reset = 1'b1;
      ex_valid = 1'b1; ex_regwrite = 1'b1; ex_memread = 1'b1; flush = 1'b0;
      ex_rd = 5'd3; id_regA = 5'd3; id_regB = 5'd3;
      ex_alu_result = 64'hDEAD; mem_rdata = 64'hBEEF;
      model_reset();
      @(posedge clk); #1;
      check_reset_values();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Table-driven vectors, each from RUN with a bubble afterwards
      for (int i = 0; i < 11; i++) begin
         step(vecs[i].in, s);
         chk($sformatf("tbl%0d_stall", i), 64'(s),          64'(vecs[i].exp_stall));
         chk($sformatf("tbl%0d_exw", i),   64'(ExRegWrite), 64'(vecs[i].exp_exw));
         chk($sformatf("tbl%0d_exrd", i),  64'(ExRd),       64'(vecs[i].exp_exrd));
         step(bub, s);
      end

      // ALU result flows EX/MEM then MEM/WB
      step(mk(1'b1,1'b1,1'b0,1'b0,5'd5,5'd0,5'd0,64'h1234,64'd0), s);
      chk("alu_exw",  64'(ExRegWrite), 64'd1);
      chk("alu_exrd", 64'(ExRd),       64'd5);
      chk("alu_exres", ex_mem_result,  64'h1234);
      step(bub, s);
      chk("alu_memrd", 64'(MemRd),  64'd5);
      chk("alu_wbdat", wb_data,     64'h1234);
      chk("alu_wben",  64'(wb_en),  64'd1);
      step(bub, s);

      // Dependent load: one stall, then HOLD; load data written back
      cnt0 = int'(stall_count);
      step(ld3, s);
      chk("ld_stall", 64'(s), 64'd1);
      chk("ld_cnt", 64'(stall_count), 64'(cnt0 + 1));
      step(mk(1'b0,1'b0,1'b0,1'b0,5'd0,5'd9,5'd3,64'd0,64'hBEEF), s);
      chk("hold_stall", 64'(s), 64'd0);
      chk("ld_wbdat", wb_data,    64'hBEEF);
      chk("ld_wbrd",  64'(wb_rd), 64'd3);
      // Back-to-back dependent loads alternate stall / no stall
      step(ld3, s);  chk("b2b_0", 64'(s), 64'd1);
      step(ld3, s);  chk("b2b_1", 64'(s), 64'd0);
      step(ld3, s);  chk("b2b_2", 64'(s), 64'd1);
      step(bub, s);

      // Flushed load: no stall, bubble captured, never written back
      step(mk(1'b1,1'b1,1'b1,1'b1,5'd3,5'd3,5'd3,64'h10,64'd0), s);
      chk("fl_stall", 64'(s), 64'd0);
      chk("fl_exw",  64'(ExRegWrite), 64'd0);
      chk("fl_exrd", 64'(ExRd),       64'd31);
      step(bub, s);
      chk("fl_wben", 64'(wb_en), 64'd0);
      step(bub, s);

      // Reset asserted during HOLD with valid contents
      step(ld3, s);
      chk("pre_rst_exw", 64'(ExRegWrite), 64'd1);
      reset = 1'b1;
      #1;
      model_reset();
      check_reset_values();
      @(posedge clk); #1;
      chk("rst_hazard_stall", 64'(stall), 64'd0);
      @(negedge clk);
      ex_valid = 1'b0;
      reset = 1'b0;

      // Randomized traffic against the model
      for (int i = 0; i < 2000; i++) begin
         in_t r;
         logic [4:0] pick [4];
         pick[0] = 5'd1; pick[1] = 5'd2; pick[2] = 5'd3; pick[3] = 5'd31;
         r.valid = ($urandom_range(0, 7) != 0);
         r.rw    = ($urandom_range(0, 3) != 0);
         r.mr    = $urandom_range(0, 1) == 1;
         r.fl    = ($urandom_range(0, 7) == 0);
         r.rd    = pick[$urandom_range(0, 3)];
         r.ra    = 5'($urandom_range(0, 4));
         r.rb    = 5'($urandom_range(0, 4));
         r.alu   = {$urandom, $urandom};
         r.rdata = {$urandom, $urandom};
         step(r, s);
      end

      // Saturation: reset the counter, then stream dependent loads
      @(negedge clk);
      reset = 1'b1;
      #1;
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 2 * int'(SAT) + 40; i++) begin
         step(ld3, s);
      end
      chk("sat_value", 64'(stall_count), 64'(SAT));
      step(ld3, s);
      step(ld3, s);
      chk("sat_hold", 64'(stall_count), 64'(SAT));
      check_regs();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
